// File: rtl/dmem_seq_arb.sv
// dmem_seq_arb: round-robin arbiter + word-to-byte sequencer for the
// 128 x 8 data memory. Two requesters (CPU MEM stage, debug/loader) share
// one byte port; each 32-bit access becomes four big-endian byte beats.
module dmem_seq_arb #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // CPU port
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_err_o,
    output logic              cpu_stall_o,
    // debug / loader port
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [31:0]       dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic [31:0]       dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              dbg_err_o,
    // byte memory
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state, state_nx;
    logic [1:0]          beat;
    logic                own_dbg;     // owner of the transfer in flight
    logic                pref_dbg;    // debug wins the next tie
    logic                we_q;
    logic [ADDR_W-3:0]   addr_q;      // word index; upper address bits dropped
    logic [31:0]         wdata_q;
    logic [23:0]         rbuf;        // bytes from beats 0..2
    logic [31:0]         cpu_rdata_q, dbg_rdata_q;
    logic                cpu_err_q, dbg_err_q;

    logic                any_req, win_dbg, win_we, win_mis;
    logic [31:0]         win_addr, win_wdata, rd_word;
    logic                unused_addr_hi;

    // Arbitration: a lone requester wins; on a tie the port not granted last wins.
    assign any_req   = cpu_req_i | dbg_req_i;
    assign win_dbg   = dbg_req_i & (~cpu_req_i | pref_dbg);
    assign win_we    = win_dbg ? dbg_we_i    : cpu_we_i;
    assign win_addr  = win_dbg ? dbg_addr_i  : cpu_addr_i;
    assign win_wdata = win_dbg ? dbg_wdata_i : cpu_wdata_i;
    assign win_mis   = (win_addr[1:0] != 2'b00);
    assign unused_addr_hi = ^win_addr[31:ADDR_W];

    // Final beat byte arrives combinationally; writes return zero data.
    assign rd_word = we_q ? 32'h0 : {rbuf, mem_rdata_i};

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_err_o   = cpu_err_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign dbg_err_o   = dbg_err_q;

    // Freeze the pipeline while the CPU waits; released in its ack cycle.
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o & ~rst_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and memory/ack strobes.
    always_comb begin
        state_nx    = state;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 8'h00;
        cpu_ack_o   = 1'b0;
        dbg_ack_o   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nx = win_mis ? DONE : XFER;
            end
            XFER: begin
                mem_en_o   = 1'b1;
                mem_we_o   = we_q;
                mem_addr_o = {addr_q, beat};
                if (we_q) mem_wdata_o = wdata_q[{~beat, 3'b000} +: 8];
                if (beat == 2'd3) state_nx = DONE;
            end
            DONE: begin
                cpu_ack_o = ~own_dbg;
                dbg_ack_o = own_dbg;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant latching, beat counting, read assembly and per-port result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat        <= 2'd0;
            own_dbg     <= 1'b0;
            pref_dbg    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rbuf        <= 24'h0;
            cpu_rdata_q <= 32'h0;
            dbg_rdata_q <= 32'h0;
            cpu_err_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        own_dbg  <= win_dbg;
                        pref_dbg <= ~win_dbg;
                        we_q     <= win_we;
                        addr_q   <= win_addr[ADDR_W-1:2];
                        wdata_q  <= win_wdata;
                        beat     <= 2'd0;
                        rbuf     <= 24'h0;
                        if (win_mis) begin
                            if (win_dbg) begin
                                dbg_rdata_q <= 32'h0;
                                dbg_err_q   <= 1'b1;
                            end else begin
                                cpu_rdata_q <= 32'h0;
                                cpu_err_q   <= 1'b1;
                            end
                        end
                    end
                end
                XFER: begin
                    beat <= beat + 2'd1;
                    if (!we_q) begin
                        case (beat)
                            2'd0:    rbuf[23:16] <= mem_rdata_i;
                            2'd1:    rbuf[15:8]  <= mem_rdata_i;
                            2'd2:    rbuf[7:0]   <= mem_rdata_i;
                            default: ;
                        endcase
                    end
                    if (beat == 2'd3) begin
                        if (own_dbg) begin
                            dbg_rdata_q <= rd_word;
                            dbg_err_q   <= 1'b0;
                        end else begin
                            cpu_rdata_q <= rd_word;
                            cpu_err_q   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_seq_arb.sv
// Bench for dmem_seq_arb: byte memory model, transaction-level reference
// checked every cycle, directed scenarios, then random two-port traffic.
module tb_dmem_seq_arb;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err;
    logic        mem_en, mem_we;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks = 0, errors = 0, en_cnt = 0;

    always #5 clk = ~clk;

    dmem_seq_arb dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err), .cpu_stall_o(cpu_stall),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack), .dbg_err_o(dbg_err),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Byte memory seen by the DUT: combinational read, write on the clock edge.
    logic [7:0] tb_mem [128];
    bit         tbm_init = 0;
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (!tbm_init) begin
            for (int i = 0; i < 128; i++) tb_mem[i] <= 8'(i * 37 + 5);
            tbm_init <= 1;
        end else if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
    end

    always @(negedge clk) if (mem_en) en_cnt++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference: a granted transaction is a list of slots (4 byte beats then
    // an ack, or just an ack when misaligned); the slot list is replayed one
    // per cycle, and the next grant is picked in the cycle after the ack.
    logic [7:0]  mm [128];
    bit          mm_init = 0;
    bit          m_act = 0, m_last_dbg = 1, m_dbg = 0, m_we = 0;
    int          m_s = 0, m_n = 0;
    logic [31:0] m_addr = 0, m_wd = 0;

    always @(negedge clk) begin
        logic       e_en, e_we, e_cack, e_dack;
        logic [6:0] e_addr, a;
        logic [7:0] e_wd;
        logic [31:0] e_rd;
        if (!mm_init) begin
            for (int i = 0; i < 128; i++) mm[i] = 8'(i * 37 + 5);
            mm_init = 1;
        end
        if (rst_i) begin
            chk("rst_strobes", {10'h0, mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, cpu_err,
                                cpu_stall, dbg_ack, dbg_err}, 32'h0);
            chk("rst_cpu_rdata", cpu_rdata, 32'h0);
            chk("rst_dbg_rdata", dbg_rdata, 32'h0);
            m_act = 0;
            m_last_dbg = 1;
        end else begin
            e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_cack = 0; e_dack = 0;
            if (m_act) begin
                if (m_s < m_n - 1) begin
                    e_en   = 1;
                    e_we   = m_we;
                    e_addr = m_addr[6:0] + 7'(m_s);
                    if (m_we) begin
                        e_wd = m_wd[8 * (3 - m_s) +: 8];
                        mm[e_addr] = e_wd;
                    end
                end else begin
                    e_cack = !m_dbg;
                    e_dack = m_dbg;
                    a = m_addr[6:0];
                    e_rd = (m_n == 1) ? 32'h0 : {mm[a], mm[a + 7'd1], mm[a + 7'd2], mm[a + 7'd3]};
                    if (m_dbg) begin
                        chk("dbg_err", dbg_err, m_n == 1);
                        if (m_n == 1 || !m_we) chk("dbg_rdata", dbg_rdata, e_rd);
                    end else begin
                        chk("cpu_err", cpu_err, m_n == 1);
                        if (m_n == 1 || !m_we) chk("cpu_rdata", cpu_rdata, e_rd);
                    end
                end
            end
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            if (e_en) chk("mem_addr", mem_addr, e_addr);
            if (e_en && e_we) chk("mem_wdata", mem_wdata, e_wd);
            chk("cpu_ack", cpu_ack, e_cack);
            chk("dbg_ack", dbg_ack, e_dack);
            chk("cpu_stall", cpu_stall, cpu_req && !e_cack);
            // advance to what the next edge produces
            if (m_act) begin
                if (m_s == m_n - 1) m_act = 0;
                else m_s++;
            end else if (cpu_req || dbg_req) begin
                m_dbg      = dbg_req && (!cpu_req || !m_last_dbg);
                m_last_dbg = m_dbg;
                m_we       = m_dbg ? dbg_we : cpu_we;
                m_addr     = m_dbg ? dbg_addr : cpu_addr;
                m_wd       = m_dbg ? dbg_wdata : cpu_wdata;
                m_s        = 0;
                m_n        = (m_addr[1:0] != 2'b00) ? 1 : 5;
                m_act      = 1;
            end
        end
    end

    // One access from posedge+1; returns latency in cycles after the sampling edge.
    task automatic do_access(input bit d, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output logic er, output int lat, output int stl);
        if (d) begin dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1; end
        else   begin cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1; end
        lat = -1; stl = 0; rd = 32'hx; er = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (cpu_stall) stl++;
            if (d ? dbg_ack : cpu_ack) begin
                lat = n - 1;
                rd  = d ? dbg_rdata : cpu_rdata;
                er  = d ? dbg_err : cpu_err;
                break;
            end
        end
        @(posedge clk); #1;
        if (d) dbg_req = 0; else cpu_req = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_i = 1;
        @(posedge clk); #1 rst_i = 0;
    endtask

    // Protocol-following random requester.
    task automatic agent(input bit d, input int nops);
        logic [31:0] a;
        bit got;
        for (int k = 0; k < nops; k++) begin
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            if (d) begin dbg_we = 1'($urandom_range(0, 1)); dbg_addr = a; dbg_wdata = $urandom; dbg_req = 1; end
            else   begin cpu_we = 1'($urandom_range(0, 1)); cpu_addr = a; cpu_wdata = $urandom; cpu_req = 1; end
            got = 0;
            for (int t = 0; t < 60 && !got; t++) begin
                @(negedge clk);
                got = d ? dbg_ack : cpu_ack;
            end
            chk(d ? "dbg_ack_seen" : "cpu_ack_seen", got, 1);
            @(posedge clk); #1;
            if ($urandom_range(0, 2) != 0) begin
                if (d) dbg_req = 0; else cpu_req = 0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end
        if (d) dbg_req = 0; else cpu_req = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, stl, ca, da, acks, en0;
        logic [7:0]  o18, o19;

        #1 rst_i = 1;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;

        // 1: CPU write then read
        do_access(0, 1, 32'h08, 32'h11223344, rd, er, lat, stl);
        chk("t1_wr_lat", lat, 5);
        chk("t1_wr_stall", stl, 5);
        chk("t1_mem", {tb_mem[8], tb_mem[9], tb_mem[10], tb_mem[11]}, 32'h11223344);
        do_access(0, 0, 32'h08, 0, rd, er, lat, stl);
        chk("t1_rd_data", rd, 32'h11223344);
        chk("t1_rd_lat", lat, 5);
        chk("t1_rd_stall", stl, 5);

        // 2: ties after reset, CPU first each time
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            cpu_we = 0; cpu_addr = 32'h00; cpu_req = 1;
            dbg_we = 0; dbg_addr = 32'h04; dbg_req = 1;
            ca = 0; da = 0;
            for (int n = 1; n <= 40 && da == 0; n++) begin
                @(negedge clk);
                if (cpu_ack && ca == 0) ca = n;
                if (dbg_ack && da == 0) da = n;
                @(posedge clk); #1;
                if (ca == n) cpu_req = 0;
                if (da == n) dbg_req = 0;
            end
            cpu_req = 0; dbg_req = 0;
            chk($sformatf("t2_cpu_ack_cycle_%0d", r), ca, 6);
            chk($sformatf("t2_dbg_after_cpu_%0d", r), da - ca, 6);
        end

        // 3: misaligned CPU read
        en0 = en_cnt;
        do_access(0, 0, 32'h06, 0, rd, er, lat, stl);
        chk("t3_lat", lat, 1);
        chk("t3_err", er, 1);
        chk("t3_rdata", rd, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_no_mem_en", en_cnt - en0, 0);

        // 4: address wrap through the debug port
        do_access(1, 1, 32'h84, 32'hDEADBEEF, rd, er, lat, stl);
        chk("t4_mem", {tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]}, 32'hDEADBEEF);
        do_access(1, 0, 32'h04, 0, rd, er, lat, stl);
        chk("t4_rd", rd, 32'hDEADBEEF);
        chk("t4_lat", lat, 5);

        // 5: reset during beat 2 of a CPU write
        o18 = tb_mem[18]; o19 = tb_mem[19];
        cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hAABBCCDD; cpu_req = 1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1;
        #1;
        chk("t5_imm_zero", {mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, cpu_stall}, 0);
        @(posedge clk); #1 cpu_req = 0;
        @(posedge clk); #1 rst_i = 0;
        chk("t5_partial", {tb_mem[16], tb_mem[17], tb_mem[18], tb_mem[19]}, {8'hAA, 8'hBB, o18, o19});
        do_access(0, 0, 32'h10, 0, rd, er, lat, stl);
        chk("t5_fresh_rd", rd, {8'hAA, 8'hBB, o18, o19});
        chk("t5_fresh_lat", lat, 5);

        // 6: CPU drops req during beat 1
        en0 = en_cnt;
        cpu_we = 0; cpu_addr = 32'h08; cpu_req = 1;
        @(posedge clk); @(posedge clk); #1 cpu_req = 0;
        acks = 0;
        repeat (12) begin @(negedge clk); if (cpu_ack) acks++; end
        chk("t6_acks", acks, 1);
        chk("t6_beats", en_cnt - en0, 4);
        @(posedge clk); #1;

        // random two-port traffic
        fork
            agent(0, 150);
            agent(1, 150);
        join
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 128; i++) chk($sformatf("mem_final_%0d", i), tb_mem[i], mm[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
